// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//
// Purpose:
//    Bundles the pipeline-register fields read by pipe_hazard_ctrl and the
//    control selects it produces, so the datapath and the control block
//    connect through a single port.
//
// Parameters:
//    CNT_W  width of the debug event counters (must match the block's CNT_W)
//
// Modports:
//    master  pipeline side: drives the decode/hazard fields, reads selects
//    slave   control block: reads the fields, drives selects and counters
//
// Signal groups:
//    ALU decode   alu_op, func25, funct3, func30          -> alu_ctrl
//    Forwarding   ex_mem_reg_write, mem_wb_reg_write,
//                 ex_mem_rd, mem_wb_rd, id_ex_rs1/rs2      -> forward_a/b,
//                                                             forwarding_active
//    Branch stall if_id_rs1/rs2, id_ex_rd, can_branch      -> stall
//    Debug        stall_cnt, fwd_cnt
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);

   // ALU-control decode (ID/EX fields)
   logic [1:0]       alu_op;
   logic             func25;
   logic [2:0]       funct3;
   logic             func30;
   logic [4:0]       alu_ctrl;

   // EX-stage forwarding
   logic             ex_mem_reg_write;
   logic             mem_wb_reg_write;
   logic [4:0]       ex_mem_rd;
   logic [4:0]       mem_wb_rd;
   logic [4:0]       id_ex_rs1;
   logic [4:0]       id_ex_rs2;
   logic [1:0]       forward_a;
   logic [1:0]       forward_b;
   logic             forwarding_active;

   // ID-stage branch hazard
   logic [4:0]       if_id_rs1;
   logic [4:0]       if_id_rs2;
   logic [4:0]       id_ex_rd;
   logic             can_branch;
   logic             stall;

   // Debug event counters
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] fwd_cnt;

   modport master (
      output alu_op, func25, funct3, func30,
      output ex_mem_reg_write, mem_wb_reg_write, ex_mem_rd, mem_wb_rd,
      output id_ex_rs1, id_ex_rs2,
      output if_id_rs1, if_id_rs2, id_ex_rd, can_branch,
      input  alu_ctrl, forward_a, forward_b, forwarding_active, stall,
      input  stall_cnt, fwd_cnt
   );

   modport slave (
      input  alu_op, func25, funct3, func30,
      input  ex_mem_reg_write, mem_wb_reg_write, ex_mem_rd, mem_wb_rd,
      input  id_ex_rs1, id_ex_rs2,
      input  if_id_rs1, if_id_rs2, id_ex_rd, can_branch,
      output alu_ctrl, forward_a, forward_b, forwarding_active, stall,
      output stall_cnt, fwd_cnt
   );

endinterface : pipe_hazard_ctrl_if

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Purpose:
//    Pipeline control for the 5-stage RV32 datapath:
//      * ALU-control decode for the EX stage (RV32I + M extension)
//      * EX-stage operand forwarding select (EX/MEM over MEM/WB)
//      * ID-stage load/ALU-to-branch hazard stall (branches resolve in ID)
//    plus two saturating debug counters (stall cycles, forwarding cycles).
//
// Parameters:
//    CNT_W   width of stall_cnt / fwd_cnt (default 16)
//
// Ports:
//    clk     system clock, rising edge
//    rst     asynchronous, active-high reset (clears the counters only)
//    bus     pipe_hazard_ctrl_if.slave
//              alu_ctrl, forward_a/b, forwarding_active, stall are
//              combinational with zero latency; stall_cnt and fwd_cnt are
//              registered.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   pipe_hazard_ctrl_if.slave bus
);

   // ------------------------------------------------------------------------
   // ALU function encoding
   // ------------------------------------------------------------------------
   typedef enum logic [4:0] {
      ALU_ADD    = 5'b00000,
      ALU_SUB    = 5'b00001,
      ALU_SLL    = 5'b00010,
      ALU_SLT    = 5'b00011,
      ALU_SLTU   = 5'b00100,
      ALU_XOR    = 5'b00101,
      ALU_SRL    = 5'b00110,
      ALU_SRA    = 5'b00111,
      ALU_OR     = 5'b01000,
      ALU_AND    = 5'b01001,
      ALU_MUL    = 5'b10000,
      ALU_MULH   = 5'b10001,
      ALU_MULHSU = 5'b10010,
      ALU_MULHU  = 5'b10011,
      ALU_DIV    = 5'b10100,
      ALU_DIVU   = 5'b10101,
      ALU_REM    = 5'b10110,
      ALU_REMU   = 5'b10111
   } alu_fn_e;

   // ALU operation class supplied by the main decoder
   typedef enum logic [1:0] {
      OP_ADD   = 2'b00,   // loads, stores, LUI/AUIPC, JAL/JALR
      OP_SUB   = 2'b01,   // branch compare
      OP_RTYPE = 2'b10,   // register-register ALU / M extension
      OP_ITYPE = 2'b11    // register-immediate ALU
   } alu_class_e;

   // Forwarding select encoding
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,    // register file value from ID/EX
      FWD_WB  = 2'b01,    // writeback data
      FWD_MEM = 2'b10     // EX/MEM ALU result
   } fwd_sel_e;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // ------------------------------------------------------------------------
   // Shared RV32I funct3 map. 'alt' is instruction bit 30, which selects
   // SUB over ADD and SRA over SRL. The I-type caller masks it for funct3
   // 000 because ADDI has no subtract form.
   // ------------------------------------------------------------------------
   function automatic alu_fn_e base_fn(input logic [2:0] f3, input logic alt);
      alu_fn_e fn;
      case (f3)
         3'b000:  fn = alt ? ALU_SUB : ALU_ADD;
         3'b001:  fn = ALU_SLL;
         3'b010:  fn = ALU_SLT;
         3'b011:  fn = ALU_SLTU;
         3'b100:  fn = ALU_XOR;
         3'b101:  fn = alt ? ALU_SRA : ALU_SRL;
         3'b110:  fn = ALU_OR;
         default: fn = ALU_AND;
      endcase
      return fn;
   endfunction

   // ------------------------------------------------------------------------
   // Forward select for one source operand. The youngest producer (EX/MEM)
   // wins; x0 is hard-wired zero so a write to it is never forwarded.
   // ------------------------------------------------------------------------
   function automatic fwd_sel_e fwd_sel(
      input logic       mem_we,
      input logic [4:0] mem_rd,
      input logic       wb_we,
      input logic [4:0] wb_rd,
      input logic [4:0] rs
   );
      fwd_sel_e sel;
      if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
         sel = FWD_MEM;
      end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_RF;
      end
      return sel;
   endfunction

   // ------------------------------------------------------------------------
   // ALU-control decode
   // ------------------------------------------------------------------------
   alu_fn_e    alu_fn;
   alu_class_e alu_class;

   assign alu_class = alu_class_e'(bus.alu_op);

   always_comb begin
      // NOTE: every variable written in a combinational block gets a default
      // first so that no path leaves it unassigned and a latch is inferred.
      alu_fn = ALU_ADD;
      case (alu_class)
         OP_ADD: alu_fn = ALU_ADD;
         OP_SUB: alu_fn = ALU_SUB;
         OP_RTYPE: begin
            if (bus.func25) begin
               // M extension: funct3 picks MUL..REMU directly
               alu_fn = alu_fn_e'({2'b10, bus.funct3});
            end else begin
               alu_fn = base_fn(bus.funct3, bus.func30);
            end
         end
         OP_ITYPE: begin
            // func25 is immediate bit 5 here, so it is not an M marker.
            // Bit 30 only matters for SRAI/SRLI.
            if (bus.funct3 == 3'b000) begin
               alu_fn = ALU_ADD;
            end else begin
               alu_fn = base_fn(bus.funct3, bus.func30);
            end
         end
         default: alu_fn = ALU_ADD;
      endcase
   end

   assign bus.alu_ctrl = alu_fn;

   // ------------------------------------------------------------------------
   // EX-stage forwarding
   // ------------------------------------------------------------------------
   fwd_sel_e fwd_a;
   fwd_sel_e fwd_b;
   logic     fwd_any;

   assign fwd_a = fwd_sel(bus.ex_mem_reg_write, bus.ex_mem_rd,
                          bus.mem_wb_reg_write, bus.mem_wb_rd, bus.id_ex_rs1);
   assign fwd_b = fwd_sel(bus.ex_mem_reg_write, bus.ex_mem_rd,
                          bus.mem_wb_reg_write, bus.mem_wb_rd, bus.id_ex_rs2);

   assign fwd_any = (fwd_a != FWD_RF) || (fwd_b != FWD_RF);

   assign bus.forward_a         = fwd_a;
   assign bus.forward_b         = fwd_b;
   assign bus.forwarding_active = fwd_any;

   // ------------------------------------------------------------------------
   // ID-stage branch hazard. A branch compares its operands in ID, so a
   // producer still in EX cannot be forwarded in time and the branch must
   // wait one cycle. Non-branches pick their operands up via EX forwarding.
   // ------------------------------------------------------------------------
   logic rd_hits_src;
   logic stall_now;

   assign rd_hits_src = (bus.id_ex_rd == bus.if_id_rs1) ||
                        (bus.id_ex_rd == bus.if_id_rs2);

   assign stall_now = bus.can_branch && (bus.id_ex_rd != 5'd0) && rd_hits_src;

   assign bus.stall = stall_now;

   // ------------------------------------------------------------------------
   // Saturating debug counters. Reset acts immediately and asynchronously;
   // the combinational controls above are not gated by it.
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] fwd_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: registered state is updated with non-blocking assignments so
      // every flop samples pre-edge values regardless of statement order.
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (stall_now && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_cnt_q <= '0;
      end else if (fwd_any && (fwd_cnt_q != CNT_MAX)) begin
         fwd_cnt_q <= fwd_cnt_q + CNT_ONE;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.fwd_cnt   = fwd_cnt_q;

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl. Two instances run side by side:
// dut (CNT_W=16) and dut2 (CNT_W=2, sharing dut's inputs) so saturation is
// reachable in a few cycles. Expected values are pushed to scoreboard queues
// as stimulus is driven and popped when outputs are sampled.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();
   pipe_hazard_ctrl_if #(.CNT_W(2))  bus2 ();

   pipe_hazard_ctrl #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
   pipe_hazard_ctrl #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

   // second instance mirrors every input of the first
   assign bus2.alu_op           = bus.alu_op;
   assign bus2.func25           = bus.func25;
   assign bus2.funct3           = bus.funct3;
   assign bus2.func30           = bus.func30;
   assign bus2.ex_mem_reg_write = bus.ex_mem_reg_write;
   assign bus2.mem_wb_reg_write = bus.mem_wb_reg_write;
   assign bus2.ex_mem_rd        = bus.ex_mem_rd;
   assign bus2.mem_wb_rd        = bus.mem_wb_rd;
   assign bus2.id_ex_rs1        = bus.id_ex_rs1;
   assign bus2.id_ex_rs2        = bus.id_ex_rs2;
   assign bus2.if_id_rs1        = bus.if_id_rs1;
   assign bus2.if_id_rs2        = bus.if_id_rs2;
   assign bus2.id_ex_rd         = bus.id_ex_rd;
   assign bus2.can_branch       = bus.can_branch;

   int n_checks = 0;
   int n_fail   = 0;

   // ------------------------------------------------------------------------
   // Scoreboards
   // ------------------------------------------------------------------------
   typedef struct packed {
      logic [1:0] fa;
      logic [1:0] fb;
      logic       act;
   } fwd_exp_t;

   typedef struct packed {
      logic [15:0] st16;
      logic [15:0] fw16;
      logic [1:0]  st2;
      logic [1:0]  fw2;
   } cnt_exp_t;

   logic [4:0] alu_q[$];
   fwd_exp_t   fwd_q[$];
   logic       stall_q[$];
   cnt_exp_t   cnt_q[$];

   function automatic logic [1:0] sat2(input int v);
      return (v > 3) ? 2'd3 : v[1:0];
   endfunction

   task automatic clear_inputs();
      bus.alu_op = 2'b00;  bus.func25 = 1'b0;  bus.funct3 = 3'b000;
      bus.func30 = 1'b0;
      bus.ex_mem_reg_write = 1'b0;  bus.mem_wb_reg_write = 1'b0;
      bus.ex_mem_rd = 5'd0;  bus.mem_wb_rd = 5'd0;
      bus.id_ex_rs1 = 5'd0;  bus.id_ex_rs2 = 5'd0;
      bus.if_id_rs1 = 5'd0;  bus.if_id_rs2 = 5'd0;
      bus.id_ex_rd  = 5'd0;  bus.can_branch = 1'b0;
   endtask

   task automatic set_fwd(input logic mw, input logic [4:0] mrd,
                          input logic ww, input logic [4:0] wrd,
                          input logic [4:0] rs1, input logic [4:0] rs2);
      bus.ex_mem_reg_write = mw;  bus.ex_mem_rd = mrd;
      bus.mem_wb_reg_write = ww;  bus.mem_wb_rd = wrd;
      bus.id_ex_rs1 = rs1;        bus.id_ex_rs2 = rs2;
   endtask

   task automatic set_branch(input logic br, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2);
      bus.can_branch = br;  bus.id_ex_rd = rd;
      bus.if_id_rs1 = rs1;  bus.if_id_rs2 = rs2;
   endtask

   // ------------------------------------------------------------------------
   // Reset: counters held at zero through clock edges; combinational decode
   // still follows its inputs while rst is high.
   // ------------------------------------------------------------------------
   task automatic test_reset();
      logic [4:0] e;
      clear_inputs();
      set_branch(1'b1, 5'd7, 5'd7, 5'd0);
      set_fwd(1'b1, 5'd4, 1'b0, 5'd0, 5'd4, 5'd0);
      bus.alu_op = 2'b01;
      alu_q.push_back(5'b00001);
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.stall_cnt !== 16'd0) begin
         n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt);
      end
      n_checks++;
      if (bus.fwd_cnt !== 16'd0) begin
         n_fail++; $display("FAIL reset_fwd_cnt: got %0d want 0", bus.fwd_cnt);
      end
      n_checks++;
      if (bus2.stall_cnt !== 2'd0 || bus2.fwd_cnt !== 2'd0) begin
         n_fail++; $display("FAIL reset_cnt_w2: got %0d/%0d want 0/0",
                            bus2.stall_cnt, bus2.fwd_cnt);
      end
      e = alu_q.pop_front();
      n_checks++;
      if (bus.alu_ctrl !== e) begin
         n_fail++; $display("FAIL reset_alu_comb: got %b want %b", bus.alu_ctrl, e);
      end
      n_checks++;
      if (bus.stall !== 1'b1 || bus.forwarding_active !== 1'b1) begin
         n_fail++; $display("FAIL reset_comb_outputs: stall=%b fwd_act=%b want 1/1",
                            bus.stall, bus.forwarding_active);
      end
      clear_inputs();
   endtask

   // ------------------------------------------------------------------------
   // ALU-control decode table
   // ------------------------------------------------------------------------
   typedef struct packed {
      logic [1:0] op;
      logic       f25;
      logic [2:0] f3;
      logic       f30;
      logic [4:0] exp;
   } alu_vec_t;

   task automatic test_alu_decode();
      alu_vec_t vecs[20];
      logic [4:0] e;
      vecs = '{
         '{2'b10, 1'b0, 3'b000, 1'b1, 5'b00001},   // SUB
         '{2'b10, 1'b0, 3'b101, 1'b1, 5'b00111},   // SRA
         '{2'b10, 1'b1, 3'b100, 1'b0, 5'b10100},   // DIV
         '{2'b10, 1'b0, 3'b000, 1'b0, 5'b00000},   // ADD
         '{2'b10, 1'b0, 3'b001, 1'b0, 5'b00010},   // SLL
         '{2'b10, 1'b0, 3'b010, 1'b0, 5'b00011},   // SLT
         '{2'b10, 1'b0, 3'b011, 1'b0, 5'b00100},   // SLTU
         '{2'b10, 1'b0, 3'b100, 1'b0, 5'b00101},   // XOR
         '{2'b10, 1'b0, 3'b101, 1'b0, 5'b00110},   // SRL
         '{2'b10, 1'b0, 3'b110, 1'b0, 5'b01000},   // OR
         '{2'b10, 1'b0, 3'b111, 1'b0, 5'b01001},   // AND
         '{2'b10, 1'b1, 3'b011, 1'b1, 5'b10011},   // MULHU, func30 ignored
         '{2'b10, 1'b1, 3'b000, 1'b0, 5'b10000},   // MUL
         '{2'b11, 1'b0, 3'b000, 1'b1, 5'b00000},   // ADDI ignores func30
         '{2'b11, 1'b1, 3'b000, 1'b1, 5'b00000},   // ADDI ignores func25
         '{2'b11, 1'b0, 3'b101, 1'b1, 5'b00111},   // SRAI
         '{2'b11, 1'b0, 3'b101, 1'b0, 5'b00110},   // SRLI
         '{2'b11, 1'b1, 3'b111, 1'b0, 5'b01001},   // ANDI, not REMU
         '{2'b00, 1'b1, 3'b111, 1'b1, 5'b00000},   // load/store ADD
         '{2'b01, 1'b0, 3'b010, 1'b1, 5'b00001}    // branch SUB
      };
      foreach (vecs[i]) begin
         bus.alu_op = vecs[i].op;   bus.func25 = vecs[i].f25;
         bus.funct3 = vecs[i].f3;   bus.func30 = vecs[i].f30;
         alu_q.push_back(vecs[i].exp);
         #1;
         e = alu_q.pop_front();
         n_checks++;
         if (bus.alu_ctrl !== e) begin
            n_fail++;
            $display("FAIL alu_decode[%0d] op=%b f25=%b f3=%b f30=%b: got %b want %b",
                     i, vecs[i].op, vecs[i].f25, vecs[i].f3, vecs[i].f30,
                     bus.alu_ctrl, e);
         end
      end
      clear_inputs();
   endtask

   // ------------------------------------------------------------------------
   // Forwarding: priority, per-operand selection, x0 and write-enable gating
   // ------------------------------------------------------------------------
   typedef struct packed {
      logic       mw;
      logic [4:0] mrd;
      logic       ww;
      logic [4:0] wrd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      fwd_exp_t   exp;
   } fwd_vec_t;

   task automatic test_forwarding();
      fwd_vec_t vecs[7];
      fwd_exp_t e;
      vecs = '{
         '{1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd6, '{2'b10, 2'b00, 1'b1}}, // both match: EX/MEM wins
         '{1'b1, 5'd5, 1'b1, 5'd6, 5'd5, 5'd6, '{2'b10, 2'b01, 1'b1}}, // rs2 from WB
         '{1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 5'd9, '{2'b00, 2'b00, 1'b0}}, // x0 never forwarded
         '{1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, '{2'b00, 2'b00, 1'b0}}, // x0 from WB either
         '{1'b0, 5'd8, 1'b0, 5'd8, 5'd8, 5'd8, '{2'b00, 2'b00, 1'b0}}, // no write enable
         '{1'b1, 5'd31, 1'b0, 5'd2, 5'd31, 5'd31, '{2'b10, 2'b10, 1'b1}},
         '{1'b0, 5'd3, 1'b1, 5'd12, 5'd1, 5'd12, '{2'b00, 2'b01, 1'b1}}
      };
      foreach (vecs[i]) begin
         set_fwd(vecs[i].mw, vecs[i].mrd, vecs[i].ww, vecs[i].wrd,
                 vecs[i].rs1, vecs[i].rs2);
         fwd_q.push_back(vecs[i].exp);
         #1;
         e = fwd_q.pop_front();
         n_checks++;
         if (bus.forward_a !== e.fa || bus.forward_b !== e.fb ||
             bus.forwarding_active !== e.act) begin
            n_fail++;
            $display("FAIL forwarding[%0d]: got a=%b b=%b act=%b want a=%b b=%b act=%b",
                     i, bus.forward_a, bus.forward_b, bus.forwarding_active,
                     e.fa, e.fb, e.act);
         end
      end
      clear_inputs();
   endtask

   // ------------------------------------------------------------------------
   // Branch stall detection
   // ------------------------------------------------------------------------
   task automatic test_stall_detect();
      logic [14:0] vecs[6];   // {can_branch, rd, rs1, rs2} minus exp packing
      logic        exps[6];
      logic        e;
      vecs[0] = {1'b1, 5'd3, 5'd0};  exps[0] = 1'b1;  // rs2 match (rs2 below)
      vecs[1] = {1'b1, 5'd0, 5'd0};  exps[1] = 1'b0;  // x0
      vecs[2] = {1'b0, 5'd3, 5'd3};  exps[2] = 1'b0;  // not a branch
      vecs[3] = {1'b1, 5'd9, 5'd9};  exps[3] = 1'b1;  // rs1 match
      vecs[4] = {1'b1, 5'd9, 5'd8};  exps[4] = 1'b0;  // no match
      vecs[5] = {1'b1, 5'd31, 5'd31}; exps[5] = 1'b1;
      foreach (vecs[i]) begin
         bus.can_branch = vecs[i][10];
         bus.id_ex_rd   = vecs[i][9:5];
         bus.if_id_rs1  = vecs[i][4:0];
         bus.if_id_rs2  = (i == 0) ? 5'd3 : ((i == 4) ? 5'd10 : 5'd0);
         stall_q.push_back(exps[i]);
         #1;
         e = stall_q.pop_front();
         n_checks++;
         if (bus.stall !== e) begin
            n_fail++;
            $display("FAIL stall_detect[%0d] rd=%0d rs1=%0d rs2=%0d br=%b: got %b want %b",
                     i, bus.id_ex_rd, bus.if_id_rs1, bus.if_id_rs2,
                     bus.can_branch, bus.stall, e);
         end
      end
      clear_inputs();
   endtask

   // ------------------------------------------------------------------------
   // Stall counter: four stall cycles out of reset, per-cycle scoreboard
   // ------------------------------------------------------------------------
   task automatic test_stall_cnt();
      cnt_exp_t e;
      @(negedge clk);
      clear_inputs();
      rst = 1'b0;
      set_branch(1'b1, 5'd3, 5'd1, 5'd3);
      for (int k = 1; k <= 4; k++) begin
         cnt_q.push_back('{16'(k), 16'd0, sat2(k), 2'd0});
         @(negedge clk);
         e = cnt_q.pop_front();
         n_checks++;
         if (bus.stall_cnt !== e.st16 || bus.fwd_cnt !== e.fw16) begin
            n_fail++;
            $display("FAIL stall_cnt cycle %0d: got st=%0d fw=%0d want st=%0d fw=%0d",
                     k, bus.stall_cnt, bus.fwd_cnt, e.st16, e.fw16);
         end
      end
      clear_inputs();
      @(negedge clk);
      n_checks++;
      if (bus.stall_cnt !== 16'd4) begin
         n_fail++; $display("FAIL stall_cnt_hold: got %0d want 4", bus.stall_cnt);
      end
   endtask

   // ------------------------------------------------------------------------
   // Asynchronous reset between edges clears without a clock edge
   // ------------------------------------------------------------------------
   task automatic test_async_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.stall_cnt !== 16'd0 || bus2.stall_cnt !== 2'd0) begin
         n_fail++;
         $display("FAIL async_reset: got %0d/%0d want 0/0",
                  bus.stall_cnt, bus2.stall_cnt);
      end
      #1;
      rst = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   // Saturation: five stall cycles then six forwarding cycles; the 2-bit
   // instance must stop at 3 while the 16-bit one keeps counting.
   // ------------------------------------------------------------------------
   task automatic test_saturation();
      cnt_exp_t e;
      @(negedge clk);
      rst = 1'b1;
      #1;
      rst = 1'b0;
      set_branch(1'b1, 5'd4, 5'd4, 5'd0);
      for (int k = 1; k <= 5; k++) begin
         cnt_q.push_back('{16'(k), 16'd0, sat2(k), 2'd0});
         @(negedge clk);
         e = cnt_q.pop_front();
         n_checks++;
         if (bus.stall_cnt !== e.st16 || bus2.stall_cnt !== e.st2) begin
            n_fail++;
            $display("FAIL stall_sat cycle %0d: got w16=%0d w2=%0d want w16=%0d w2=%0d",
                     k, bus.stall_cnt, bus2.stall_cnt, e.st16, e.st2);
         end
      end
      clear_inputs();
      set_fwd(1'b0, 5'd0, 1'b1, 5'd7, 5'd0, 5'd7);
      for (int k = 1; k <= 6; k++) begin
         cnt_q.push_back('{16'd5, 16'(k), 2'd3, sat2(k)});
         @(negedge clk);
         e = cnt_q.pop_front();
         n_checks++;
         if (bus.fwd_cnt !== e.fw16 || bus2.fwd_cnt !== e.fw2 ||
             bus.stall_cnt !== e.st16 || bus2.stall_cnt !== e.st2) begin
            n_fail++;
            $display("FAIL fwd_sat cycle %0d: got fw=%0d/%0d st=%0d/%0d want fw=%0d/%0d st=%0d/%0d",
                     k, bus.fwd_cnt, bus2.fwd_cnt, bus.stall_cnt, bus2.stall_cnt,
                     e.fw16, e.fw2, e.st16, e.st2);
         end
      end
      clear_inputs();
   endtask

   // ------------------------------------------------------------------------
   // Back-to-back random traffic against an independent model of the
   // combinational controls and both counters.
   // ------------------------------------------------------------------------
   task automatic test_back_to_back();
      int       m_st = 0;
      int       m_fw = 0;
      fwd_exp_t ef;
      logic     es;
      cnt_exp_t ec;
      @(negedge clk);
      rst = 1'b1;
      #1;
      rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         set_branch(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         // model: later assignment overrides earlier, giving EX/MEM priority
         ef.fa = 2'b00;
         if (bus.mem_wb_reg_write && bus.mem_wb_rd != 0 && bus.mem_wb_rd == bus.id_ex_rs1) ef.fa = 2'b01;
         if (bus.ex_mem_reg_write && bus.ex_mem_rd != 0 && bus.ex_mem_rd == bus.id_ex_rs1) ef.fa = 2'b10;
         ef.fb = 2'b00;
         if (bus.mem_wb_reg_write && bus.mem_wb_rd != 0 && bus.mem_wb_rd == bus.id_ex_rs2) ef.fb = 2'b01;
         if (bus.ex_mem_reg_write && bus.ex_mem_rd != 0 && bus.ex_mem_rd == bus.id_ex_rs2) ef.fb = 2'b10;
         ef.act = (ef.fa != 2'b00) || (ef.fb != 2'b00);
         es = bus.can_branch && (bus.id_ex_rd != 0) &&
              ((bus.id_ex_rd == bus.if_id_rs1) || (bus.id_ex_rd == bus.if_id_rs2));
         fwd_q.push_back(ef);
         stall_q.push_back(es);
         if (es) m_st++;
         if (ef.act) m_fw++;
         cnt_q.push_back('{16'(m_st), 16'(m_fw), sat2(m_st), sat2(m_fw)});
         #1;
         ef = fwd_q.pop_front();
         es = stall_q.pop_front();
         n_checks++;
         if (bus.forward_a !== ef.fa || bus.forward_b !== ef.fb ||
             bus.forwarding_active !== ef.act || bus.stall !== es) begin
            n_fail++;
            $display("FAIL b2b_comb[%0d]: got a=%b b=%b act=%b st=%b want a=%b b=%b act=%b st=%b",
                     k, bus.forward_a, bus.forward_b, bus.forwarding_active, bus.stall,
                     ef.fa, ef.fb, ef.act, es);
         end
         @(negedge clk);
         ec = cnt_q.pop_front();
         n_checks++;
         if (bus.stall_cnt !== ec.st16 || bus.fwd_cnt !== ec.fw16 ||
             bus2.stall_cnt !== ec.st2 || bus2.fwd_cnt !== ec.fw2) begin
            n_fail++;
            $display("FAIL b2b_cnt[%0d]: got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d",
                     k, bus.stall_cnt, bus.fwd_cnt, bus2.stall_cnt, bus2.fwd_cnt,
                     ec.st16, ec.fw16, ec.st2, ec.fw2);
         end
      end
      clear_inputs();
   endtask

   // ------------------------------------------------------------------------
   // Sequence
   // ------------------------------------------------------------------------
   initial begin
      clear_inputs();
      rst = 1'b1;
      test_reset();
      test_alu_decode();
      test_forwarding();
      test_stall_detect();
      test_stall_cnt();
      test_async_reset();
      test_saturation();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_pipe_hazard_ctrl

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline control block for the 5-stage RV32 datapath. It combines three functions:
- ALU-control decode for the EX stage.
- EX-stage operand forwarding selection.
- ID-stage branch-hazard stall detection (branches resolve in ID).

It sits between the pipeline registers and the ALU/PC logic. It also keeps registered event counters for debug.

Parameters:
CNT_W, 16, width of the saturating stall and forward event counters.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
alu_op  in  2  ALU operation class from ID/EX.
func25  in  1  instruction bit 25 (M-extension marker) from ID/EX.
funct3  in  3  instruction funct3 from ID/EX.
func30  in  1  instruction bit 30 from ID/EX.
alu_ctrl  out  5  ALU function select (combinational).
ex_mem_reg_write  in  1  EX/MEM register-write enable.
mem_wb_reg_write  in  1  MEM/WB register-write enable.
ex_mem_rd  in  5  EX/MEM destination register.
mem_wb_rd  in  5  MEM/WB destination register.
id_ex_rs1  in  5  ID/EX source register 1.
id_ex_rs2  in  5  ID/EX source register 2.
forward_a  out  2  operand-A select: 00 register file, 10 EX/MEM ALU result, 01 writeback data.
forward_b  out  2  operand-B select, same encoding as forward_a.
if_id_rs1  in  5  IF/ID source register 1.
if_id_rs2  in  5  IF/ID source register 2.
id_ex_rd  in  5  ID/EX destination register.
can_branch  in  1  instruction in ID is a branch.
stall  out  1  freeze PC and IF/ID, bubble ID/EX (combinational).
forwarding_active  out  1  forward_a != 00 or forward_b != 00.
stall_cnt  out  CNT_W  registered count of stall cycles, saturating.
fwd_cnt  out  CNT_W  registered count of cycles with forwarding_active, saturating.

Behaviour:
- alu_ctrl, forward_a/b, stall and forwarding_active are purely combinational, with zero latency.
- ALU control encoding: ADD 00000, SUB 00001, SLL 00010, SLT 00011, SLTU 00100, XOR 00101, SRL 00110, SRA 00111, OR 01000, AND 01001, MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
- alu_op=00 -> ADD, for loads, stores, LUI/AUIPC and JAL/JALR.
- alu_op=01 -> SUB, for branches.
- alu_op=10 (R-type):
  - if func25=1 -> 10 followed by funct3, i.e. {2'b10, funct3}, covering the M extension.
  - otherwise funct3 000 -> SUB if func30=1, else ADD.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 101 -> SRA if func30=1, else SRL.
- alu_op=11 (I-type ALU):
  - same funct3 map as R-type, but 000 is always ADD (func30 ignored).
  - 101 uses func30 for SRAI/SRLI.
  - func25 is ignored.
- Forwarding, operand A (B is identical using id_ex_rs2):
  - 10 if ex_mem_reg_write && ex_mem_rd!=0 && ex_mem_rd==id_ex_rs1.
  - else 01 if mem_wb_reg_write && mem_wb_rd!=0 && mem_wb_rd==id_ex_rs1.
  - else 00.
  - EX/MEM has priority when both stages match.
- Stall: stall = can_branch && id_ex_rd!=0 && (id_ex_rd==if_id_rs1 || id_ex_rd==if_id_rs2).
  - Never stalls on x0.
  - Non-branch instructions never stall.
- Counters, on each rising clk:
  - stall_cnt increments when stall=1.
  - fwd_cnt increments when forwarding_active=1.
  - Both saturate at all-ones and never wrap.
- Reset: rst=1 asynchronously forces stall_cnt=0 and fwd_cnt=0.
  - Combinational outputs follow their inputs regardless of rst.
  - Asserting reset mid-count clears immediately, without waiting for a clock edge.

Test Plan:
1. alu_op=10, func25=0, funct3=000, func30=1 -> alu_ctrl=00001. Then funct3=101, func30=1 -> 00111. Then func25=1, funct3=100 -> 10100.
2. alu_op=11, funct3=000, func30=1 -> alu_ctrl=00000 (ADDI). alu_op=00 with any funct -> 00000. alu_op=01 -> 00001.
3. ex_mem_reg_write=1, ex_mem_rd=5, mem_wb_reg_write=1, mem_wb_rd=5, id_ex_rs1=5, id_ex_rs2=6 -> forward_a=10, forward_b=00, forwarding_active=1. Then set mem_wb_rd=6 -> forward_b=01.
4. ex_mem_rd=0 with reg_write=1 and id_ex_rs1=0 -> forward_a=00.
5. can_branch=1, id_ex_rd=3, if_id_rs2=3 -> stall=1.
   - id_ex_rd=0 with if_id_rs1=0 -> stall=0.
   - can_branch=0 with a matching register -> stall=0.
6. Hold stall=1 for 4 cycles -> stall_cnt=4.
   - Pulse rst asynchronously between clock edges -> stall_cnt=0 immediately.
   - With CNT_W=2, hold stall for 5 cycles -> stall_cnt stays at 3.
